// File: rtl/ecpri_pkg.sv
// rtl/ecpri_pkg.sv - header offsets, frame constants and enums for the eCPRI RMA response builder
package ecpri_pkg;

    localparam int HDR_DST_MAC = 0;
    localparam int HDR_SRC_MAC = 6;
    localparam int HDR_ETYPE   = 12;
    localparam int HDR_CMN     = 14;
    localparam int HDR_RMA_ID  = 18;
    localparam int HDR_RW_RR   = 19;
    localparam int HDR_ELEM_ID = 20;
    localparam int HDR_ADDR    = 22;
    localparam int HDR_LEN     = 28;

    localparam int ETH_HDR_LEN   = 14;
    localparam int CMN_HDR_LEN   = 4;
    localparam int RMA_HDR_LEN   = 12;
    localparam int FRAME_HDR_LEN = ETH_HDR_LEN + CMN_HDR_LEN + RMA_HDR_LEN;

    localparam logic [7:0] ECPRI_REV_BYTE = 8'h10;
    localparam logic [7:0] MSG_RMA        = 8'h04;
    localparam logic [3:0] RESP_NIBBLE    = 4'h1;

    localparam int MIN_FRAME = 60;

    typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_STREAM, ST_DONE} state_t;

    // Where a frame byte comes from; SRC_HDR_RESP is a header byte with its low nibble forced
    typedef enum logic [1:0] {SRC_CONST, SRC_HDR, SRC_HDR_RESP, SRC_PAY} src_t;

endpackage

// File: rtl/ecpri_tx_byte_sel.sv
// rtl/ecpri_tx_byte_sel.sv - maps a frame byte index to its source RAM/address or constant value
// ECPRI_TX_PAD_EN: pad frames shorter than MIN_FRAME with zero bytes
module ecpri_tx_byte_sel
    import ecpri_pkg::*;
#(
    parameter int          DATA_WIDTH   = 8,
    parameter int          ADDR_WIDTH   = 16,
    parameter logic [15:0] ETH_TYPE     = 16'hAEFE,
    parameter int          PAYLOAD_BASE = 0
) (
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic                  is_read,
    input  logic [DATA_WIDTH-1:0] pay_len,
    output src_t                  src,
    output logic [ADDR_WIDTH-1:0] hdr_addr,
    output logic [ADDR_WIDTH-1:0] pay_addr,
    output logic [DATA_WIDTH-1:0] const_byte,
    output logic [ADDR_WIDTH-1:0] frame_len
);

    function automatic logic [ADDR_WIDTH-1:0] a(input int n);
        return ADDR_WIDTH'(n);
    endfunction

    logic [ADDR_WIDTH-1:0] d_len;
    logic [ADDR_WIDTH-1:0] body_len;
    logic [15:0]           msg_len;

    assign d_len    = is_read ? ADDR_WIDTH'(pay_len) : '0;
    assign body_len = a(FRAME_HDR_LEN) + d_len;
    assign msg_len  = 16'(RMA_HDR_LEN) + 16'(d_len);
    assign pay_addr = a(PAYLOAD_BASE) + idx - a(FRAME_HDR_LEN);

`ifdef ECPRI_TX_PAD_EN
    assign frame_len = (body_len < a(MIN_FRAME)) ? a(MIN_FRAME) : body_len;
`else
    assign frame_len = body_len;
`endif

    always_comb begin
        src        = SRC_CONST;
        hdr_addr   = idx;
        const_byte = '0;
        // MAC addresses are swapped so the response goes back to the requester
        if (idx < a(HDR_SRC_MAC)) begin
            src      = SRC_HDR;
            hdr_addr = idx + a(HDR_SRC_MAC);
        end else if (idx < a(HDR_ETYPE)) begin
            src      = SRC_HDR;
            hdr_addr = idx - a(HDR_SRC_MAC);
        end else if (idx == a(HDR_ETYPE)) begin
            const_byte = DATA_WIDTH'(ETH_TYPE[15:8]);
        end else if (idx == a(HDR_ETYPE + 1)) begin
            const_byte = DATA_WIDTH'(ETH_TYPE[7:0]);
        end else if (idx == a(HDR_CMN)) begin
            const_byte = DATA_WIDTH'(ECPRI_REV_BYTE);
        end else if (idx == a(HDR_CMN + 1)) begin
            const_byte = DATA_WIDTH'(MSG_RMA);
        end else if (idx == a(HDR_CMN + 2)) begin
            const_byte = DATA_WIDTH'(msg_len[15:8]);
        end else if (idx == a(HDR_CMN + 3)) begin
            const_byte = DATA_WIDTH'(msg_len[7:0]);
        end else if (idx == a(HDR_RW_RR)) begin
            src = SRC_HDR_RESP;
        end else if (idx < a(HDR_LEN)) begin
            src = SRC_HDR;
        end else if (idx < a(FRAME_HDR_LEN)) begin
            if (is_read) begin
                const_byte = (idx == a(HDR_LEN)) ? '0 : pay_len;
            end else begin
                src = SRC_HDR;
            end
        end else if (idx < body_len) begin
            src = SRC_PAY;
        end
    end

endmodule

// File: rtl/ecpri_tx_resp.sv
// rtl/ecpri_tx_resp.sv - builds the eCPRI RMA response frame byte by byte into the tx eth RAM
// ECPRI_TX_PAD_EN (in ecpri_tx_byte_sel): pad short frames to MIN_FRAME bytes
module ecpri_tx_resp
    import ecpri_pkg::*;
#(
    parameter int          DATA_WIDTH   = 8,
    parameter int          ADDR_WIDTH   = 16,
    parameter logic [15:0] ETH_TYPE     = 16'hAEFE,
    parameter int          PAYLOAD_BASE = 0,
    parameter int          TX_BASE      = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  send_write_resp,
    input  logic                  send_read_resp,
    input  logic [DATA_WIDTH-1:0] resp_payload_len,
    output logic                  busy,
    output logic                  tx_done,
    output logic [ADDR_WIDTH-1:0] tx_frame_len,
    output logic [ADDR_WIDTH-1:0] addr_0,
    inout  wire  [DATA_WIDTH-1:0] data_0,
    output logic                  we_0,
    output logic                  oe_0,
    output logic [ADDR_WIDTH-1:0] addr_1,
    inout  wire  [DATA_WIDTH-1:0] data_1,
    output logic                  we_1,
    output logic                  oe_1,
    output logic [ADDR_WIDTH-1:0] addr_2,
    inout  wire  [DATA_WIDTH-1:0] data_2,
    output logic                  we_2,
    output logic                  oe_2
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] n_q;
    logic                  is_read_q;
    logic [DATA_WIDTH-1:0] len_q;
    src_t                  iss_src;
    src_t                  wr_src;
    logic [DATA_WIDTH-1:0] iss_const;
    logic [DATA_WIDTH-1:0] wr_const;
    logic [DATA_WIDTH-1:0] wr_byte;

    logic                  idle;
    logic                  accept;
    logic                  in_frame;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] sel_idx;
    logic                  sel_read;
    logic [DATA_WIDTH-1:0] sel_len;
    src_t                  sel_src;
    logic [ADDR_WIDTH-1:0] sel_hdr_addr;
    logic [ADDR_WIDTH-1:0] sel_pay_addr;
    logic [DATA_WIDTH-1:0] sel_const;
    logic [ADDR_WIDTH-1:0] sel_frame_len;

    assign we_0 = 1'b0;
    assign we_1 = 1'b0;
    assign oe_2 = 1'b0;

    assign idle     = (state == ST_IDLE);
    assign accept   = idle && (send_read_resp || send_write_resp);
    assign in_frame = (state == ST_PRIME) || (state == ST_STREAM);
    // idx is the next byte whose source read is issued; the write of idx-1 happens alongside
    assign issue    = accept || (in_frame && (idx < n_q));
    // On acceptance the request inputs are not latched yet, so byte 0 is selected from them directly
    assign sel_idx  = idle ? '0 : idx;
    assign sel_read = idle ? send_read_resp : is_read_q;
    assign sel_len  = idle ? resp_payload_len : len_q;

    ecpri_tx_byte_sel #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .ETH_TYPE    (ETH_TYPE),
        .PAYLOAD_BASE(PAYLOAD_BASE)
    ) u_byte_sel (
        .idx       (sel_idx),
        .is_read   (sel_read),
        .pay_len   (sel_len),
        .src       (sel_src),
        .hdr_addr  (sel_hdr_addr),
        .pay_addr  (sel_pay_addr),
        .const_byte(sel_const),
        .frame_len (sel_frame_len)
    );

    always_comb begin
        wr_byte = wr_const;
        case (wr_src)
            SRC_HDR:      wr_byte = data_0;
            SRC_HDR_RESP: wr_byte = {data_0[DATA_WIDTH-1:4], RESP_NIBBLE};
            SRC_PAY:      wr_byte = data_1;
            default:      wr_byte = wr_const;
        endcase
    end

    assign data_2 = we_2 ? wr_byte : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            tx_done      <= 1'b0;
            tx_frame_len <= '0;
            addr_0       <= '0;
            addr_1       <= '0;
            addr_2       <= '0;
            oe_0         <= 1'b0;
            oe_1         <= 1'b0;
            we_2         <= 1'b0;
            idx          <= '0;
            n_q          <= '0;
            is_read_q    <= 1'b0;
            len_q        <= '0;
            iss_src      <= SRC_CONST;
            wr_src       <= SRC_CONST;
            iss_const    <= '0;
            wr_const     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_PRIME;
                        busy      <= 1'b1;
                        is_read_q <= send_read_resp;
                        len_q     <= resp_payload_len;
                        n_q       <= sel_frame_len;
                        idx       <= ADDR_WIDTH'(1);
                    end
                end
                ST_PRIME, ST_STREAM: begin
                    if (idx > n_q) begin
                        state        <= ST_DONE;
                        busy         <= 1'b0;
                        we_2         <= 1'b0;
                        tx_done      <= 1'b1;
                        tx_frame_len <= n_q;
                    end else begin
                        state    <= ST_STREAM;
                        we_2     <= 1'b1;
                        addr_2   <= ADDR_WIDTH'(TX_BASE) + idx - ADDR_WIDTH'(1);
                        wr_src   <= iss_src;
                        wr_const <= iss_const;
                        idx      <= idx + ADDR_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    tx_done <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase

            if (issue) begin
                if (sel_src == SRC_HDR || sel_src == SRC_HDR_RESP) begin
                    addr_0 <= sel_hdr_addr;
                end
                if (sel_src == SRC_PAY) begin
                    addr_1 <= sel_pay_addr;
                end
                oe_0      <= (sel_src == SRC_HDR) || (sel_src == SRC_HDR_RESP);
                oe_1      <= (sel_src == SRC_PAY);
                iss_src   <= sel_src;
                iss_const <= sel_const;
            end else begin
                oe_0 <= 1'b0;
                oe_1 <= 1'b0;
            end
        end
    end

endmodule
